// File: rtl/forth_cpu_v2_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : forth_cpu_v2_if                                                 |
// | Purpose  : Bundles the program-ROM port, the data memory bus and the       |
// |            interrupt request/acknowledge lines of forth_cpu_v2.            |
// | Ports    : code_address/code_data  synchronous ROM byte port               |
// |            mem_*                   request/ready data bus                  |
// |            interrupt/interrupt_ack level requests, one-hot ack pulse       |
// |            master = CPU side, slave = ROM/memory/interrupt controller side |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface forth_cpu_v2_if #(
   parameter int WIDTH     = 16,
   parameter int ROM_BITS  = 8,
   parameter int INT_COUNT = 2
);
   logic [ROM_BITS-1:0]  code_address;
   logic [7:0]           code_data;
   logic [WIDTH-1:0]     mem_address;
   logic [WIDTH-1:0]     mem_data_out;
   logic [WIDTH-1:0]     mem_data_in;
   logic                 mem_valid;
   logic                 mem_nwr;
   logic                 mem_ready;
   logic [INT_COUNT-1:0] interrupt;
   logic [INT_COUNT-1:0] interrupt_ack;

   modport master (
      output code_address, mem_address, mem_data_out, mem_valid, mem_nwr, interrupt_ack,
      input  code_data, mem_data_in, mem_ready, interrupt
   );

   modport slave (
      input  code_address, mem_address, mem_data_out, mem_valid, mem_nwr, interrupt_ack,
      output code_data, mem_data_in, mem_ready, interrupt
   );
endinterface
`default_nettype wire

// File: rtl/forth_cpu_v2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : forth_cpu_v2                                                    |
// | Purpose  : Stack CPU with depth-checked data/call stacks, prioritised      |
// |            maskable interrupts and an external synchronous code port.      |
// | Ports    : clk, reset      clock and synchronous active-high reset         |
// |            bus (master)    ROM port, memory bus, interrupt lines           |
// |            hlt / wfi       high while halted / waiting for interrupt       |
// |            error           sticky fault flag                               |
// |            error_code      1 illegal op, 2 data stack, 3 call stack        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module forth_cpu_v2 #(
   parameter int WIDTH     = 16,
   parameter int DS_DEPTH  = 16,
   parameter int CS_DEPTH  = 16,
   parameter int ROM_BITS  = 8,
   parameter int INT_COUNT = 2
) (
   input  wire logic      clk,
   input  wire logic      reset,
   forth_cpu_v2_if.master bus,
   output logic           hlt,
   output logic           wfi,
   output logic           error,
   output logic [1:0]     error_code
);
   localparam int IMM_BYTES = WIDTH / 8;
   localparam int DS_PTR    = (DS_DEPTH > 1) ? $clog2(DS_DEPTH) : 1;
   localparam int DS_CNT    = $clog2(DS_DEPTH + 1);
   localparam int CS_PTR    = (CS_DEPTH > 1) ? $clog2(CS_DEPTH) : 1;
   localparam int CS_CNT    = $clog2(CS_DEPTH + 1);
   localparam int CNT_W     = (IMM_BYTES > 1) ? $clog2(IMM_BYTES) : 1;
   localparam int IRQ_W     = (INT_COUNT > 1) ? $clog2(INT_COUNT) : 1;

   localparam logic [7:0] OP_PUSH = 8'h00, OP_DUP  = 8'h01, OP_SET  = 8'h02, OP_JMP  = 8'h03;
   localparam logic [7:0] OP_GET  = 8'h04, OP_CALL = 8'h05, OP_RET  = 8'h06, OP_HLT  = 8'h07;
   localparam logic [7:0] OP_WFI  = 8'h08, OP_BR   = 8'h09, OP_BR0  = 8'h0A, OP_RETI = 8'h0B;
   localparam logic [7:0] OP_DROP = 8'h0C, OP_SWAP = 8'h0D, OP_EI   = 8'h0E, OP_DI   = 8'h0F;

   typedef enum logic [2:0] {
      ST_FETCH, ST_EXEC, ST_IMM, ST_MEM, ST_WFI, ST_HALT, ST_ERROR
   } state_t;

   state_t               state, state_next;
   logic [ROM_BITS-1:0]  pc;
   logic                 ie;
   logic [WIDTH-1:0]     ds [DS_DEPTH];
   logic [DS_CNT-1:0]    ds_depth;
   logic [ROM_BITS-1:0]  cs [CS_DEPTH];
   logic [CS_CNT-1:0]    cs_depth;
   logic [7:0]           op_reg;
   logic [WIDTH-1:0]     imm_reg;
   logic [CNT_W-1:0]     byte_cnt;
   logic                 req_valid, req_nwr;
   logic [WIDTH-1:0]     req_addr, req_data;
   logic [INT_COUNT-1:0] ack_pulse;
   logic [1:0]           fault_code, next_fault;

   // Stack views: the top entry lives at index depth-1
   logic [DS_PTR-1:0]    tos_idx, nos_idx, push_idx;
   logic [CS_PTR-1:0]    cs_top_idx, cs_push_idx;
   logic [WIDTH-1:0]     tos, nos, alu, imm_full;
   logic [ROM_BITS-1:0]  cs_top, irq_vector;

   assign tos_idx     = DS_PTR'(ds_depth - 1'b1);
   assign nos_idx     = DS_PTR'(ds_depth - 2'd2);
   assign push_idx    = DS_PTR'(ds_depth);
   assign cs_top_idx  = CS_PTR'(cs_depth - 1'b1);
   assign cs_push_idx = CS_PTR'(cs_depth);
   assign tos         = ds[tos_idx];
   assign nos         = ds[nos_idx];
   assign cs_top      = cs[cs_top_idx];

   // Decode of the opcode byte presented during EXEC
   logic [1:0] ds_need;
   logic       ds_push, cs_need, cs_push, legal, br_taken;
   logic       ds_fault, cs_full, cs_fault, imm_last;

   always_comb begin
      ds_need = 2'd0;
      ds_push = 1'b0;
      cs_need = 1'b0;
      cs_push = 1'b0;
      legal   = 1'b1;
      case (bus.code_data)
         OP_PUSH:                 ds_push = 1'b1;
         OP_DUP:                  begin ds_need = 2'd1; ds_push = 1'b1; end
         OP_SET, OP_SWAP:         ds_need = 2'd2;
         OP_GET, OP_BR, OP_BR0,
         OP_DROP:                 ds_need = 2'd1;
         OP_CALL:                 cs_push = 1'b1;
         OP_RET, OP_RETI:         cs_need = 1'b1;
         OP_JMP, OP_HLT, OP_WFI,
         OP_EI, OP_DI:            legal = 1'b1;
         8'hF0, 8'hF1, 8'hF2, 8'hF3, 8'hF4,
         8'hF5, 8'hF6, 8'hF7, 8'hF8: ds_need = 2'd2;
         default:                 legal = 1'b0;
      endcase
   end

   assign ds_fault = (DS_CNT'(ds_need) > ds_depth) ||
                     (ds_push && (ds_depth == DS_CNT'(DS_DEPTH)));
   assign cs_full  = (cs_depth == CS_CNT'(CS_DEPTH));
   assign cs_fault = (cs_need && (cs_depth == '0)) || (cs_push && cs_full);
   assign br_taken = (bus.code_data == OP_BR) ? (tos != '0) : (tos == '0);
   assign imm_last = (byte_cnt == CNT_W'(IMM_BYTES - 1));

   // Operands are NOS (left) and TOS (right): "a b -" yields a-b
   always_comb begin
      alu = '0;
      case (bus.code_data[3:0])
         4'h0:    alu = nos + tos;
         4'h1:    alu = nos & tos;
         4'h2:    alu = nos | tos;
         4'h3:    alu = nos ^ tos;
         4'h4:    alu = {{(WIDTH-1){1'b0}}, nos >  tos};
         4'h5:    alu = {{(WIDTH-1){1'b0}}, nos >= tos};
         4'h6:    alu = {{(WIDTH-1){1'b0}}, nos <= tos};
         4'h7:    alu = {{(WIDTH-1){1'b0}}, nos <  tos};
         4'h8:    alu = nos - tos;
         default: alu = '0;
      endcase
   end

   // Little-endian immediate: the byte arriving now fills slot byte_cnt
   always_comb begin
      imm_full = imm_reg;
      imm_full[byte_cnt*8 +: 8] = bus.code_data;
   end

   // Lowest-index pending request wins
   logic                 irq_hit;
   logic [IRQ_W-1:0]     irq_idx;
   logic [INT_COUNT-1:0] irq_onehot;

   always_comb begin
      irq_hit    = 1'b0;
      irq_idx    = '0;
      irq_onehot = '0;
      for (int i = INT_COUNT - 1; i >= 0; i--) begin
         if (bus.interrupt[i]) begin
            irq_hit       = 1'b1;
            irq_idx       = IRQ_W'(i);
            irq_onehot    = '0;
            irq_onehot[i] = 1'b1;
         end
      end
   end

   assign irq_vector = ROM_BITS'((int'(irq_idx) + 1) * 4);

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= ST_FETCH;
      else       state <= state_next;
   end

   // Next state and fault classification
   always_comb begin
      state_next = state;
      next_fault = 2'd0;
      case (state)
         ST_FETCH: begin
            if (ie && irq_hit) begin
               if (cs_full) begin
                  state_next = ST_ERROR;
                  next_fault = 2'd3;
               end
            end else begin
               state_next = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (!legal) begin
               state_next = ST_ERROR;
               next_fault = 2'd1;
            end else if (ds_fault) begin
               state_next = ST_ERROR;
               next_fault = 2'd2;
            end else if (cs_fault) begin
               state_next = ST_ERROR;
               next_fault = 2'd3;
            end else begin
               case (bus.code_data)
                  OP_PUSH, OP_JMP, OP_CALL: state_next = ST_IMM;
                  OP_BR, OP_BR0:            state_next = br_taken ? ST_IMM : ST_FETCH;
                  OP_SET, OP_GET:           state_next = ST_MEM;
                  OP_HLT:                   state_next = ST_HALT;
                  OP_WFI:                   state_next = ST_WFI;
                  default:                  state_next = ST_FETCH;
               endcase
            end
         end
         ST_IMM:   if (imm_last) state_next = ST_FETCH;
         ST_MEM:   if (bus.mem_ready) state_next = ST_FETCH;
         ST_WFI:   if (bus.interrupt != '0) state_next = ST_FETCH;
         default:  state_next = state;
      endcase
   end

   // Datapath
   always_ff @(posedge clk) begin
      if (reset) begin
         pc         <= '0;
         ie         <= 1'b1;
         ds_depth   <= '0;
         cs_depth   <= '0;
         op_reg     <= '0;
         imm_reg    <= '0;
         byte_cnt   <= '0;
         req_valid  <= 1'b0;
         req_nwr    <= 1'b1;
         req_addr   <= '0;
         req_data   <= '0;
         ack_pulse  <= '0;
         fault_code <= 2'd0;
      end else begin
         ack_pulse <= '0;
         if (state != ST_ERROR && state_next == ST_ERROR)
            fault_code <= next_fault;
         case (state)
            ST_FETCH: begin
               if (ie && irq_hit) begin
                  if (!cs_full) begin
                     cs[cs_push_idx] <= pc;
                     cs_depth        <= cs_depth + 1'b1;
                     ie              <= 1'b0;
                     ack_pulse       <= irq_onehot;
                     pc              <= irq_vector;
                  end
               end else begin
                  pc <= pc + 1'b1;
               end
            end
            ST_EXEC: if (state_next != ST_ERROR) begin
               case (bus.code_data)
                  OP_PUSH, OP_JMP, OP_CALL: begin
                     pc       <= pc + 1'b1;
                     op_reg   <= bus.code_data;
                     byte_cnt <= '0;
                  end
                  OP_DUP: begin
                     ds[push_idx] <= tos;
                     ds_depth     <= ds_depth + 1'b1;
                  end
                  OP_SET: begin
                     req_valid <= 1'b1;
                     req_nwr   <= 1'b0;
                     req_addr  <= tos;
                     req_data  <= nos;
                     ds_depth  <= ds_depth - 2'd2;
                  end
                  OP_GET: begin
                     req_valid <= 1'b1;
                     req_nwr   <= 1'b1;
                     req_addr  <= tos;
                  end
                  OP_RET: begin
                     pc       <= cs_top;
                     cs_depth <= cs_depth - 1'b1;
                  end
                  OP_RETI: begin
                     pc       <= cs_top;
                     cs_depth <= cs_depth - 1'b1;
                     ie       <= 1'b1;
                  end
                  OP_BR, OP_BR0: begin
                     ds_depth <= ds_depth - 1'b1;
                     if (br_taken) begin
                        pc       <= pc + 1'b1;
                        op_reg   <= OP_JMP;
                        byte_cnt <= '0;
                     end else begin
                        // Skip the whole immediate without reading it
                        pc <= pc + ROM_BITS'(IMM_BYTES);
                     end
                  end
                  OP_DROP: ds_depth <= ds_depth - 1'b1;
                  OP_SWAP: begin
                     ds[tos_idx] <= nos;
                     ds[nos_idx] <= tos;
                  end
                  OP_EI: ie <= 1'b1;
                  OP_DI: ie <= 1'b0;
                  8'hF0, 8'hF1, 8'hF2, 8'hF3, 8'hF4,
                  8'hF5, 8'hF6, 8'hF7, 8'hF8: begin
                     ds[nos_idx] <= alu;
                     ds_depth    <= ds_depth - 1'b1;
                  end
                  default: ;
               endcase
            end
            ST_IMM: begin
               imm_reg <= imm_full;
               if (imm_last) begin
                  // pc already points past the immediate: it is the return address
                  case (op_reg)
                     OP_PUSH: begin
                        ds[push_idx] <= imm_full;
                        ds_depth     <= ds_depth + 1'b1;
                     end
                     OP_CALL: begin
                        cs[cs_push_idx] <= pc;
                        cs_depth        <= cs_depth + 1'b1;
                        pc              <= ROM_BITS'(imm_full);
                     end
                     default: pc <= ROM_BITS'(imm_full);
                  endcase
               end else begin
                  pc       <= pc + 1'b1;
                  byte_cnt <= byte_cnt + 1'b1;
               end
            end
            ST_MEM: begin
               if (bus.mem_ready) begin
                  req_valid <= 1'b0;
                  req_nwr   <= 1'b1;
                  if (req_nwr) ds[tos_idx] <= bus.mem_data_in;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.code_address  = pc;
   assign bus.mem_address   = req_addr;
   assign bus.mem_data_out  = req_data;
   assign bus.mem_valid     = req_valid;
   assign bus.mem_nwr       = req_nwr;
   assign bus.interrupt_ack = ack_pulse;
   assign hlt               = (state == ST_HALT);
   assign wfi               = (state == ST_WFI);
   assign error             = (state == ST_ERROR);
   assign error_code        = fault_code;
endmodule
`default_nettype wire
